clk_period_meter: RTL and testbench
===================================

# clk_period_meter

Debug-side measurement block that samples an asynchronous, slow debug clock (e.g. the divided or pulse-stepped clock sent to the core) and reports its period and high time in system `clk` cycles. It sits beside the debug clock generator in the debug unit. It lets the host confirm the programmed divider ratio and detect a stalled or absent debug clock through a timeout.

## Interface
Parameters:
- `COUNTER_BITS`, 32, width of all cycle counters and result registers
- `SYNC_STAGES`, 2, flip-flops in the `clk_in` synchronizer (minimum 2)

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high; clock `clk`
- `enable`  in  1  1 = measure, 0 = idle
- `clk_in`  in  1  asynchronous signal under measurement
- `timeout`  in  COUNTER_BITS  max cycles without a rising edge; 0 disables the timeout
- `period_o`  out  COUNTER_BITS  last measured rising-to-rising distance, in `clk` cycles
- `high_o`  out  COUNTER_BITS  last measured rising-to-falling distance, in `clk` cycles
- `valid_o`  out  1  one-cycle pulse when `period_o`/`high_o` update
- `timeout_o`  out  1  one-cycle pulse on timeout
- `busy_o`  out  1  high in ARM or MEASURE

## Operation
- `clk_in` passes through `SYNC_STAGES` flops, giving `s`. One more register holds `s_d`.
  - rise = `s & ~s_d`
  - fall = `~s & s_d`
- States: IDLE, ARM, MEASURE.
- IDLE:
  - `cnt` = 0.
  - Go to ARM when `enable` = 1.
- ARM:
  - Wait for rise.
  - On rise: `cnt` <= 1, go to MEASURE. No result is produced.
- MEASURE:
  - Each cycle without rise: `cnt` <= `cnt` + 1, saturating at all-ones (no wrap).
  - On fall: `high_cnt` <= `cnt`.
  - On rise:
    - `period_o` <= `cnt` and `high_o` <= `high_cnt`.
    - Pulse `valid_o`.
    - `cnt` <= 1, stay in MEASURE, so back-to-back periods are measured continuously.
- Timeout:
  - Condition: in ARM or MEASURE, `timeout` != 0, and `cnt` == `timeout` with no rise this cycle.
  - Action: pulse `timeout_o`, `cnt` <= 0, go to ARM.
  - `period_o` and `high_o` hold their values.
  - In ARM, `cnt` also increments for timeout purposes, starting from entry.
- Priority, highest first: `reset` > `enable` = 0 > rise > timeout > increment.
  - A rise and a timeout in the same cycle: the rise wins, and `timeout_o` stays 0.
- `enable` falling in any state: IDLE next cycle, no `valid_o`, results hold.
- `timeout` may change at any time and takes effect in the same cycle's compare.
- Reset values:
  - `period_o`, `high_o`, `high_cnt`, `cnt` = 0
  - `valid_o`, `timeout_o`, `busy_o` = 0
  - state = IDLE
  - synchronizer flops = 0
- Reset mid-measurement discards the partial count.

## Timing
- Edge detection latency: `SYNC_STAGES` + 1 `clk` cycles from a `clk_in` transition to rise/fall.
  - Period and high measurements are latency-invariant.
- `valid_o` is asserted in the cycle after the internal rise cycle, for exactly one cycle. Results are stable from that cycle.
- `busy_o` is registered and follows state one cycle late.
- Resolution:
  - ±1 cycle jitter for an asynchronous `clk_in`.
  - Exact when `clk_in` is generated from `clk`.
- Minimum measurable: period 2, high 1. Narrower `clk_in` pulses may be missed; no error is flagged.

## Structure
- Shared package `debug_pkg`:
  - state enum `meter_state_t` (IDLE, ARM, MEASURE)
  - `DBG_COUNTER_BITS` = 32 default constant, shared with the debug clock generator
- Sub-module `sync_edge_detect`:
  - parameter `SYNC_STAGES`
  - synchronizer plus `s_d` register
  - outputs `level`, `rise`, `fall`
  - reused elsewhere in the debug unit
- Top level holds the FSM, `cnt`, `high_cnt`, the result registers and the output pulses.

## Test plan
- Square wave from `clk`, period 10, high 5, `enable` = 1, `timeout` = 0:
  - first `valid_o` at the second rise
  - `period_o` = 10, `high_o` = 5
  - then `valid_o` every 10 cycles, values unchanged
- Duty change mid-stream to period 7, high 2: the first full new period reports 7/2, and no intermediate mixed result appears except the transition period.
- `clk_in` stuck high after one rise, `timeout` = 20:
  - `timeout_o` pulses once 20 cycles after the rise
  - state returns to ARM, `period_o` unchanged
  - reapplying the period-10 wave gives valid 10/5 again
- Rise coincident with `cnt` == `timeout` (period 12, `timeout` = 12): `valid_o` with `period_o` = 12, `timeout_o` never asserted.
- `enable` dropped mid-period:
  - `busy_o` falls, no `valid_o`, results hold
  - re-enable: ARM discards the first rise, and the first `valid_o` comes one full period later
- `reset` asserted for 1 cycle during MEASURE:
  - all outputs 0 next cycle, state IDLE
  - with `enable` still high, measurement resumes and reports the correct period

Source files
------------

// File: rtl/debug_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debug_pkg
//  Description : Shared types and constants for the debug unit: the clock
//                period meter state encoding and the default counter width
//                used by both the meter and the debug clock generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package debug_pkg;

  // Default width of cycle counters across the debug unit.
  localparam int DBG_COUNTER_BITS = 32;

  // Period meter control states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } meter_state_t;

endpackage : debug_pkg
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge_detect
//  Description : Multi-flop synchronizer for an asynchronous level, followed
//                by one delay register so single-cycle rise/fall strobes can
//                be derived in the clk domain.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  // A single flop cannot resolve metastability; refuse to elaborate.
  if (SYNC_STAGES < 2) begin : g_stage_check
    $error("sync_edge_detect: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  // Shift the async input through the synchronizer and keep one delayed copy
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      s_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  // The last synchronizer stage is the clean level; edges compare it with
  // its one-cycle-old copy.
  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~s_d;
  assign fall  = ~level & s_d;

endmodule : sync_edge_detect
`default_nettype wire

// File: rtl/clk_period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : clk_period_meter
//  Description : Measures the period and high time of an asynchronous debug
//                clock in system clk cycles, with a programmable timeout that
//                flags a stalled or absent clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_period_meter
  import debug_pkg::*;
#(
  parameter int COUNTER_BITS = DBG_COUNTER_BITS,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    clk_in,
  input  logic [COUNTER_BITS-1:0] timeout,
  output logic [COUNTER_BITS-1:0] period_o,
  output logic [COUNTER_BITS-1:0] high_o,
  output logic                    valid_o,
  output logic                    timeout_o,
  output logic                    busy_o
);

  localparam logic [COUNTER_BITS-1:0] CNT_ONE = {{(COUNTER_BITS-1){1'b0}}, 1'b1};

  meter_state_t            state;
  logic [COUNTER_BITS-1:0] cnt;
  logic [COUNTER_BITS-1:0] high_cnt;
  logic [COUNTER_BITS-1:0] cnt_inc;
  logic                    timeout_hit;
  logic                    sync_level;
  logic                    rise;
  logic                    fall;
  logic                    unused_level;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (clk_in),
    .level (sync_level),
    .rise  (rise),
    .fall  (fall)
  );

  // Only the edge strobes drive the measurement; the level is not needed.
  assign unused_level = sync_level;

  // Saturating increment: a stalled input must never wrap to a small,
  // plausible-looking period.
  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_ONE;

  // The timeout compare uses the live timeout value; a rise in the same
  // cycle always takes precedence so an exact-length period still reports.
  assign timeout_hit = (timeout != '0) && (cnt == timeout) && !rise;

  // Measurement FSM with registered result and pulse outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      high_cnt  <= '0;
      period_o  <= '0;
      high_o    <= '0;
      valid_o   <= 1'b0;
      timeout_o <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      valid_o   <= 1'b0;
      timeout_o <= 1'b0;
      busy_o    <= (state != IDLE);

      if (!enable) begin
        // Dropping enable abandons the partial count; results are kept.
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt   <= '0;
            state <= ARM;
          end

          ARM: begin
            // The first rise only establishes a phase reference.
            if (rise) begin
              cnt   <= CNT_ONE;
              state <= MEASURE;
            end else if (timeout_hit) begin
              timeout_o <= 1'b1;
              cnt       <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end

          MEASURE: begin
            if (fall) begin
              high_cnt <= cnt;
            end
            if (rise) begin
              // Close this period and immediately start the next one.
              period_o <= cnt;
              high_o   <= high_cnt;
              valid_o  <= 1'b1;
              cnt      <= CNT_ONE;
            end else if (timeout_hit) begin
              timeout_o <= 1'b1;
              cnt       <= '0;
              state     <= ARM;
            end else begin
              cnt <= cnt_inc;
            end
          end

          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule : clk_period_meter
`default_nettype wire

// File: tb/tb_clk_period_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_clk_period_meter
//  Description : Scoreboard bench for clk_period_meter. A clk-synchronous
//                wave generator pushes the expected result of every completed
//                period; a monitor pops and compares when valid_o pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_period_meter;

  localparam int CB   = 32;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          clk_in = 1'b0;
  logic [CB-1:0] timeout = '0;
  logic [CB-1:0] period_o;
  logic [CB-1:0] high_o;
  logic          valid_o;
  logic          timeout_o;
  logic          busy_o;

  always #5 clk = ~clk;

  clk_period_meter #(
    .COUNTER_BITS (CB),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .clk_in    (clk_in),
    .timeout   (timeout),
    .period_o  (period_o),
    .high_o    (high_o),
    .valid_o   (valid_o),
    .timeout_o (timeout_o),
    .busy_o    (busy_o)
  );

  typedef struct {
    int unsigned period;
    int unsigned high;
    int unsigned due;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned to_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;
  int unsigned valid_seen = 0;
  int unsigned to_seen = 0;

  // Generator state: mode 0 = low, 1 = wave, 2 = held high
  int          gen_mode = 0;
  int          phase = 0;
  int          cur_p = 10;
  int          cur_h = 5;
  int          nxt_p = 10;
  int          nxt_h = 5;
  int          skip = 0;
  bit          track = 1'b0;
  bit          hold_req = 1'b0;
  int unsigned hold_cyc = 0;

  // Drive clk_in for this cycle; at each rise the period just completed is
  // expected to be reported LAT cycles later (unless the DUT is arming).
  task automatic gen_tick();
    case (gen_mode)
      1: begin
        if (phase == 0) begin
          if (skip > 0) skip--;
          else if (track) exp_q.push_back(exp_t'{cur_p, cur_h, cyc + LAT});
          cur_p = nxt_p;
          cur_h = nxt_h;
          if (hold_req) begin
            hold_req = 1'b0;
            gen_mode = 2;
            hold_cyc = cyc;
          end
        end
        clk_in = (phase < cur_h);
        phase  = (phase + 1 >= cur_p) ? 0 : phase + 1;
      end
      2:       clk_in = 1'b1;
      default: clk_in = 1'b0;
    endcase
  endtask

  // Pop expectations when the DUT pulses, and flag anything overdue.
  task automatic mon_tick();
    exp_t        e;
    int unsigned t;
    if (valid_o === 1'b1) begin
      valid_seen++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_valid: cycle %0d period_o=%0d high_o=%0d, required no valid", cyc, period_o, high_o);
      end else begin
        e = exp_q.pop_front();
        if (period_o !== e.period) begin
          n_bad++;
          $display("FAIL period: got %0d, required %0d (cycle %0d)", period_o, e.period, cyc);
        end
        n_cmp++;
        if (high_o !== e.high) begin
          n_bad++;
          $display("FAIL high: got %0d, required %0d (cycle %0d)", high_o, e.high, cyc);
        end
        n_cmp++;
        if (cyc != e.due) begin
          n_bad++;
          $display("FAIL valid_timing: valid at cycle %0d, required cycle %0d", cyc, e.due);
        end
      end
    end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
      e = exp_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missed_valid: no valid by cycle %0d, required at cycle %0d", cyc, e.due);
    end
    if (timeout_o === 1'b1) begin
      to_seen++;
      n_cmp++;
      if (to_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_timeout: timeout_o at cycle %0d, required 0", cyc);
      end else begin
        t = to_q.pop_front();
        if (cyc != t) begin
          n_bad++;
          $display("FAIL timeout_timing: timeout_o at cycle %0d, required cycle %0d", cyc, t);
        end
      end
    end else if (to_q.size() > 0 && cyc > to_q[0]) begin
      t = to_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missed_timeout: none by cycle %0d, required at cycle %0d", cyc, t);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    gen_tick();
    mon_tick();
  endtask

  task automatic wait_valids(input int n, input int budget, input string name);
    int unsigned target;
    int          k;
    target = valid_seen + n;
    k = 0;
    while (valid_seen < target && k < budget) begin
      step();
      k++;
    end
    n_cmp++;
    if (valid_seen < target) begin
      n_bad++;
      $display("FAIL %s_wait: got %0d valids, required %0d within %0d cycles", name, n - int'(target - valid_seen), n, budget);
    end
  endtask

  task automatic wait_phase(input int p);
    int k;
    k = 0;
    while (phase != p && k < 40) begin
      step();
      k++;
    end
  endtask

  task automatic check_outputs(input string name, input int unsigned p, input int unsigned h,
                               input bit v, input bit t, input bit b);
    n_cmp++;
    if (period_o !== p) begin n_bad++; $display("FAIL %s_period_o: got %0d, required %0d", name, period_o, p); end
    n_cmp++;
    if (high_o !== h) begin n_bad++; $display("FAIL %s_high_o: got %0d, required %0d", name, high_o, h); end
    n_cmp++;
    if (valid_o !== v) begin n_bad++; $display("FAIL %s_valid_o: got %b, required %b", name, valid_o, v); end
    n_cmp++;
    if (timeout_o !== t) begin n_bad++; $display("FAIL %s_timeout_o: got %b, required %b", name, timeout_o, t); end
    n_cmp++;
    if (busy_o !== b) begin n_bad++; $display("FAIL %s_busy_o: got %b, required %b", name, busy_o, b); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b0;
    timeout = '0;
    gen_mode = 0;
    repeat (3) step();
    check_outputs("reset", 0, 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    check_outputs("post_reset", 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_square();
    enable = 1'b1;
    timeout = '0;
    cur_p = 10; cur_h = 5; nxt_p = 10; nxt_h = 5;
    phase = 0;
    skip = 1;
    track = 1'b1;
    gen_mode = 1;
    wait_valids(4, 80, "square");
    n_cmp++;
    if (busy_o !== 1'b1) begin n_bad++; $display("FAIL square_busy: got %b, required 1", busy_o); end
  endtask

  task automatic test_duty_change();
    nxt_p = 7; nxt_h = 2;
    wait_valids(4, 60, "duty_7_2");
    n_cmp++;
    if (period_o !== 7 || high_o !== 2) begin
      n_bad++;
      $display("FAIL duty_7_2_result: got %0d/%0d, required 7/2", period_o, high_o);
    end
    nxt_p = 10; nxt_h = 5;
    wait_valids(2, 40, "duty_back");
  endtask

  task automatic test_timeout();
    int k;
    int unsigned ts;
    timeout = 20;
    hold_req = 1'b1;
    k = 0;
    while (gen_mode != 2 && k < 30) begin step(); k++; end
    to_q.push_back(hold_cyc + LAT + 20);
    ts = to_seen;
    k = 0;
    while (to_seen == ts && k < 60) begin step(); k++; end
    n_cmp++;
    if (to_seen == ts) begin
      n_bad++;
      $display("FAIL timeout_wait: got no timeout_o, required one within 60 cycles");
    end
    n_cmp++;
    if (period_o !== 10 || high_o !== 5) begin
      n_bad++;
      $display("FAIL timeout_hold: got %0d/%0d, required 10/5", period_o, high_o);
    end
    step();
    n_cmp++;
    if (busy_o !== 1'b1) begin n_bad++; $display("FAIL timeout_busy: got %b, required 1", busy_o); end
    cur_p = 10; cur_h = 5; nxt_p = 10; nxt_h = 5;
    phase = 5;
    skip = 1;
    gen_mode = 1;
    wait_valids(2, 60, "timeout_recover");
    timeout = '0;
  endtask

  task automatic test_coincident();
    int unsigned ts;
    ts = to_seen;
    timeout = 12;
    nxt_p = 12; nxt_h = 6;
    wait_valids(4, 80, "coincident");
    n_cmp++;
    if (period_o !== 12 || high_o !== 6) begin
      n_bad++;
      $display("FAIL coincident_result: got %0d/%0d, required 12/6", period_o, high_o);
    end
    n_cmp++;
    if (to_seen != ts) begin
      n_bad++;
      $display("FAIL coincident_timeout: got %0d timeout pulses, required 0", to_seen - ts);
    end
    timeout = '0;
  endtask

  task automatic test_enable_drop();
    int unsigned vs;
    wait_phase(cur_h + 1);
    enable = 1'b0;
    track = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (busy_o !== 1'b0) begin n_bad++; $display("FAIL enable_drop_busy: got %b, required 0", busy_o); end
    vs = valid_seen;
    repeat (25) step();
    n_cmp++;
    if (valid_seen != vs) begin
      n_bad++;
      $display("FAIL enable_drop_valid: got %0d valids while disabled, required 0", valid_seen - vs);
    end
    n_cmp++;
    if (period_o !== 12 || high_o !== 6) begin
      n_bad++;
      $display("FAIL enable_drop_hold: got %0d/%0d, required 12/6", period_o, high_o);
    end
    wait_phase(cur_h + 1);
    enable = 1'b1;
    skip = 1;
    track = 1'b1;
    wait_valids(2, 60, "reenable");
    n_cmp++;
    if (busy_o !== 1'b1) begin n_bad++; $display("FAIL reenable_busy: got %b, required 1", busy_o); end
  endtask

  task automatic test_reset_mid();
    wait_phase(cur_h + 1);
    reset = 1'b1;
    skip = 1;
    step();
    check_outputs("mid_reset", 0, 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    wait_valids(2, 60, "after_reset");
    n_cmp++;
    if (period_o !== 12 || high_o !== 6) begin
      n_bad++;
      $display("FAIL after_reset_result: got %0d/%0d, required 12/6", period_o, high_o);
    end
  endtask

  initial begin
    test_reset();
    test_square();
    test_duty_change();
    test_timeout();
    test_coincident();
    test_enable_drop();
    test_reset_mid();
    repeat (4) step();
    n_cmp++;
    if (exp_q.size() != 0 || to_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: got %0d results and %0d timeouts outstanding, required 0", exp_q.size(), to_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_clk_period_meter
`default_nettype wire
